// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from imem and holds one word toward decode.
// Latency 1 cycle pc->out; stalls when out_valid & ~out_ready; redirects flush; bad fetches trap until rst.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic slot_free;
    logic redirect_bad;

    assign slot_free    = ~out_valid_q | out_ready;
    assign redirect_bad = (redirect_target[1:0] != 2'b00) || (redirect_target >= LIMIT);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        fault_pc_d  = fault_pc_q;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    // A word consumed this cycle is already delivered; anything else held is dropped.
                    out_valid_d = 1'b0;
                    if (redirect_bad) begin
                        state_d    = FAULT;
                        fault_pc_d = redirect_target;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (slot_free && (pc_q >= LIMIT)) begin
                    state_d     = FAULT;
                    fault_pc_d  = pc_q;
                    out_valid_d = 1'b0;
                end else if (slot_free) begin
                    out_instr_d = imem_instr;
                    out_pc_d    = pc_q;
                    out_valid_d = 1'b1;
                    pc_d        = pc_q + 32'd4;
                end
            end
            FAULT: begin
                out_valid_d = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'h0;
            out_instr_q <= 32'h0;
            fault_pc_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            fault_pc_q  <= fault_pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign fault     = (state_q == FAULT);
    assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural 64-word instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;
    logic [31:0] fault_pc;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [64];

    fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(64)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .fault(fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (imem_addr < 32'd256) imem_instr = mem[imem_addr[7:2]];
        else                     imem_instr = 32'hDEAD_BEEF;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
        step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        total++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin bad++; $display("FAIL reset_out got=%h/%h exp=0/0", out_pc, out_instr); end
        total++; if (fault_pc !== 32'h0) begin bad++; $display("FAIL reset_fault_pc got=%h exp=0", fault_pc); end
    endtask

    task automatic test_stream();
        rst = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h00A00093) begin bad++; $display("FAIL stream0 got=%b/%h/%h exp=1/00000000/00a00093", out_valid, out_pc, out_instr); end
        total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL stream0_addr got=%h exp=4", imem_addr); end
        step();
        total++; if (out_pc !== 32'h4 || out_instr !== 32'h01400113) begin bad++; $display("FAIL stream1 got=%h/%h exp=4/01400113", out_pc, out_instr); end
        step();
        total++; if (out_pc !== 32'h8 || out_instr !== 32'h10000002) begin bad++; $display("FAIL stream2 got=%h/%h exp=8/10000002", out_pc, out_instr); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== 32'h10000002 || imem_addr !== 32'hC) begin
                bad++; $display("FAIL stall_hold%0d got=%b/%h/%h/%h exp=1/8/10000002/c", i, out_valid, out_pc, out_instr, imem_addr);
            end
        end
        out_ready = 1'b1;
        step();
        total++; if (out_pc !== 32'hC || out_instr !== 32'h10000003) begin bad++; $display("FAIL stall_release got=%h/%h exp=c/10000003", out_pc, out_instr); end
        step();
        total++; if (out_pc !== 32'h10) begin bad++; $display("FAIL stall_next got=%h exp=10", out_pc); end
        step();
        total++; if (out_pc !== 32'h14) begin bad++; $display("FAIL stall_next2 got=%h exp=14", out_pc); end
    endtask

    task automatic test_redirect();
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h1C;
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b exp=0", out_valid); end
        total++; if (imem_addr !== 32'h1C) begin bad++; $display("FAIL redir_addr got=%h exp=1c", imem_addr); end
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h1C || out_instr !== 32'h10000007) begin bad++; $display("FAIL redir_target got=%b/%h/%h exp=1/1c/10000007", out_valid, out_pc, out_instr); end
        step();
        total++; if (out_pc !== 32'h20) begin bad++; $display("FAIL redir_follow got=%h exp=20", out_pc); end
    endtask

    task automatic test_fault_misaligned();
        redirect_valid = 1'b1; redirect_target = 32'h1E;
        step();
        total++; if (fault !== 1'b1 || fault_pc !== 32'h1E || out_valid !== 1'b0) begin bad++; $display("FAIL misalign got=%b/%h/%b exp=1/1e/0", fault, fault_pc, out_valid); end
        total++; if (imem_addr !== 32'h24) begin bad++; $display("FAIL misalign_pc got=%h exp=24", imem_addr); end
        redirect_target = 32'h0;
        step();
        redirect_valid = 1'b0;
        step();
        total++; if (fault !== 1'b1 || imem_addr !== 32'h24 || out_valid !== 1'b0 || fault_pc !== 32'h1E) begin bad++; $display("FAIL fault_sticky got=%b/%h/%b/%h exp=1/24/0/1e", fault, imem_addr, out_valid, fault_pc); end
    endtask

    task automatic test_reset_in_fault();
        rst = 1'b1;
        step();
        total++; if (fault !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 32'h0 || fault_pc !== 32'h0) begin bad++; $display("FAIL rst_fault got=%b/%b/%h/%h exp=0/0/0/0", fault, out_valid, imem_addr, fault_pc); end
        rst = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h00A00093) begin bad++; $display("FAIL rst_fault_restart got=%b/%h/%h exp=1/0/00a00093", out_valid, out_pc, out_instr); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pc;
        for (int k = 1; k < 64; k++) begin
            step();
            exp_pc = 32'(k * 4);
            total++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== mem[k]) begin
                bad++; $display("FAIL seq_run got=%b/%h/%h exp=1/%h/%h", out_valid, out_pc, out_instr, exp_pc, mem[k]);
            end
        end
        step();
        total++; if (fault !== 1'b1 || fault_pc !== 32'h100 || out_valid !== 1'b0) begin bad++; $display("FAIL range_fault got=%b/%h/%b exp=1/100/0", fault, fault_pc, out_valid); end
        step();
        total++; if (out_pc !== 32'hFC || imem_addr !== 32'h100) begin bad++; $display("FAIL range_frozen got=%h/%h exp=fc/100", out_pc, imem_addr); end
    endtask

    task automatic test_reset_in_stall();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin bad++; $display("FAIL pre_rst_stall got=%b/%h exp=1/4", out_valid, out_pc); end
        rst = 1'b1;
        step();
        total++; if (out_valid !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL rst_stall got=%b/%b/%h exp=0/0/0", out_valid, fault, imem_addr); end
        rst = 1'b0; out_ready = 1'b1;
        step();
        total++; if (out_pc !== 32'h0 || out_instr !== 32'h00A00093) begin bad++; $display("FAIL rst_stall_restart got=%h/%h exp=0/00a00093", out_pc, out_instr); end
    endtask

    task automatic test_redirect_range();
        // word0 delivered at this edge (fire), then redirect out of range
        redirect_valid = 1'b1; redirect_target = 32'h100;
        step();
        redirect_valid = 1'b0;
        total++; if (fault !== 1'b1 || fault_pc !== 32'h100 || out_valid !== 1'b0) begin bad++; $display("FAIL redir_range got=%b/%h/%b exp=1/100/0", fault, fault_pc, out_valid); end
        total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL redir_range_pc got=%h exp=4", imem_addr); end
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[0] = 32'h00A00093;
        mem[1] = 32'h01400113;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_fault_misaligned();
        test_reset_in_fault();
        test_overflow();
        test_reset_in_stall();
        test_redirect_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the instruction memory. It owns the program counter, drives the memory's byte address, and captures the returned word into a one-entry output register with a valid/ready handshake toward decode. It also accepts redirects (taken branch/jump) and traps misaligned or out-of-range fetches into a sticky fault state.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- MEM_WORDS, 64, instruction memory depth in 32-bit words; valid fetch range is [0, MEM_WORDS*4).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; equals the PC register (combinational).
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  one-cycle request to replace the PC.
- redirect_target  in  32  new byte address when redirect_valid=1.
- out_valid  out  1  output register holds a fetched instruction.
- out_ready  in  1  decode accepts the output this cycle.
- out_pc  out  32  byte address of out_instr.
- out_instr  out  32  fetched instruction word.
- fault  out  1  sticky fetch-fault flag.
- fault_pc  out  32  offending address that caused the fault.

## Operation

- State: pc (32b), output register {out_valid, out_pc, out_instr}, FSM {RUN, FAULT}, fault_pc.
- Reset values: pc=RESET_PC, out_valid=0, out_pc=0, out_instr=0, fault=0, fault_pc=0, FSM=RUN. rst wins over every other input, including mid-stall or in FAULT.
- fire = out_valid & out_ready. slot_free = ~out_valid | out_ready.
- Per-cycle priority in RUN, highest first:
  1. redirect_valid=1: out_valid<=0 (flush any held instruction; an instruction consumed by fire this same cycle counts as delivered). If redirect_target[1:0]!=0 or redirect_target >= MEM_WORDS*4: FSM<=FAULT, fault_pc<=redirect_target, pc unchanged. Else pc<=redirect_target. No fetch loaded this cycle.
  2. slot_free and pc >= MEM_WORDS*4: FSM<=FAULT, fault_pc<=pc, out_valid<=0.
  3. slot_free: out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+4 (32-bit modulo).
  4. Otherwise (out_valid=1, out_ready=0): hold everything.
- FAULT: fault=1 (combinational from FSM state), out_valid=0, pc frozen, redirect_valid and out_ready ignored; exit only via rst.
- imem_addr=pc at all times, including in FAULT.
- No instruction is duplicated or skipped across any stall sequence; out_pc sequence between redirects is strictly +4.

## Timing

- Fetch latency: one cycle from pc presented on imem_addr to that word on out_instr/out_valid.
- First edge with rst=0 loads RESET_PC's word; out_valid=1 from the following cycle.
- Throughput: one instruction per cycle while out_ready=1.
- Redirect penalty: out_valid=0 for exactly the cycle following the redirect edge; the target's instruction is valid one cycle after that.
- Stall: while out_valid=1 and out_ready=0, out_pc/out_instr are stable and imem_addr holds at out_pc+4.
- fault rises the cycle after the triggering edge and stays high until rst.

## Test plan

- Reset, out_ready=1, memory word0=0x00A00093, word1=0x01400113 -> out_pc 0x0,0x4,0x8… on consecutive cycles; out_instr 0x00A00093 then 0x01400113.
- out_ready=0 for 3 cycles while out_pc=0x8 -> out_pc/out_instr held, imem_addr=0xC; on release out_pc 0x8 accepted, then 0xC, no skip or duplicate.
- Redirect to 0x1C while out_valid=1, out_pc=0x14, out_ready=0 -> next cycle out_valid=0; following cycle out_pc=0x1C with word7.
- Redirect to 0x1E -> fault=1, fault_pc=0x1E, out_valid=0; a later redirect to 0x0 is ignored, fault stays 1.
- Sequential run, MEM_WORDS=64, out_ready=1 -> last delivered out_pc=0xFC, then fault=1, fault_pc=0x100, out_valid=0.
- rst pulsed during a stall and again in FAULT -> next cycle out_valid=0, fault=0, imem_addr=RESET_PC; fetch restarts at word0.
